// File: rtl/mmio_arbiter_if.sv
// Requester handshake and MMIO target bus bundle for mmio_arbiter.
// The arbiter drives through the master modport; requesters and the register target use slave.
interface mmio_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [31:0]           m_addr;
  logic [31:0]           m_wdata;
  logic                  m_wr;
  logic                  m_rd;
  logic                  m_rd_valid;
  logic [31:0]           m_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, m_rd_valid, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, m_addr, m_wdata, m_wr, m_rd
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, m_rd_valid, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_addr, m_wdata, m_wr, m_rd
  );
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one MMIO register target between NUM_REQ requesters.
// One transaction in flight: accept, strobe the target, await read data (with timeout), complete.
module mmio_arbiter #(
  parameter int          NUM_REQ   = 2,
  parameter logic [15:0] ADDR_BASE = 16'hBEEF,
  parameter int          TIMEOUT   = 8
) (
  input  logic           clk,
  input  logic           rst,
  mmio_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic               found;
  logic               accept;
  logic               cur_write;
  logic               sel_write;
  logic               sel_in_range;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [31:0]        m_addr_q;
  logic [31:0]        m_wdata_q;
  logic [31:0]        rsp_rdata_q;
  logic               m_wr_q;
  logic               m_rd_q;
  logic               rsp_err_q;
  logic [7:0]         wait_cnt;

  // Rotating priority search: first asserted request after the last granted index
  always_comb begin
    grant_oh  = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
      if (!found && bus.req_valid[cand]) begin
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
        found          = 1'b1;
      end
    end
  end

  // Grant is suppressed while reset is asserted so nothing handshakes into an aborted state
  assign accept       = rst && (state == ST_IDLE) && found;
  assign sel_addr     = bus.req_addr[32*grant_idx +: 32];
  assign sel_wdata    = bus.req_wdata[32*grant_idx +: 32];
  assign sel_write    = bus.req_write[grant_idx];
  assign sel_in_range = (sel_addr[31:16] == ADDR_BASE);

  assign bus.req_ready = accept ? grant_oh : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_wr      = m_wr_q;
  assign bus.m_rd      = m_rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      cur_idx     <= '0;
      cur_write   <= 1'b0;
      wait_cnt    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wr_q      <= 1'b0;
      m_rd_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_idx    <= grant_idx;
            cur_write  <= sel_write;
            last_grant <= grant_idx;
            if (sel_in_range) begin
              m_addr_q  <= sel_addr;
              m_wdata_q <= sel_wdata;
              m_wr_q    <= sel_write;
              m_rd_q    <= !sel_write;
              state     <= ST_ISSUE;
            end else begin
              rsp_valid_q[grant_idx] <= 1'b1;
              rsp_err_q              <= 1'b1;
              rsp_rdata_q            <= '0;
              state                  <= ST_DONE;
            end
          end
        end
        // Strobe lasts exactly one cycle; writes complete without waiting on the target
        ST_ISSUE: begin
          m_wr_q   <= 1'b0;
          m_rd_q   <= 1'b0;
          wait_cnt <= '0;
          if (cur_write) begin
            rsp_valid_q[cur_idx] <= 1'b1;
            rsp_err_q            <= 1'b0;
            rsp_rdata_q          <= '0;
            state                <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.m_rd_valid) begin
            rsp_valid_q[cur_idx] <= 1'b1;
            rsp_err_q            <= 1'b0;
            rsp_rdata_q          <= bus.m_rdata;
            state                <= ST_DONE;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            rsp_valid_q[cur_idx] <= 1'b1;
            rsp_err_q            <= 1'b1;
            rsp_rdata_q          <= '0;
            state                <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          rsp_valid_q <= '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Round-robin arbiter and transaction sequencer that shares one 4-byte-addressed MMIO register target between NUM_REQ requesters. Accepts one request at a time, issues a single-cycle write or read strobe on the target bus, waits for the target's registered read response (with timeout), and returns a one-cycle completion to the granted requester. Sits between the software-facing masters (CPU shim, DMA/test driver) and the MMIO register block.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_BASE, 16'hBEEF, required value of addr[31:16]; other addresses are rejected without bus access
- TIMEOUT, 8, max cycles spent waiting for read valid (1..255)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant/accept; handshake = req_valid[i] && req_ready[i]
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*32  requester i at [32*i+31:32*i]
- req_wdata  in  NUM_REQ*32  write data, same packing
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to requester i
- rsp_rdata  out  32  read data (shared; valid with rsp_valid)
- rsp_err  out  1  error flag (shared; valid with rsp_valid)
- m_addr  out  32  target address
- m_wdata  out  32  target write data
- m_wr  out  1  target write strobe
- m_rd  out  1  target read strobe
- m_rd_valid  in  1  target read-valid
- m_rdata  in  32  target read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready = one-hot grant of highest-priority asserted req_valid; none if no request. Round robin: search starts at last_grant+1 (mod NUM_REQ). On handshake: latch index, write, addr, wdata; update last_grant. If addr[31:16]==ADDR_BASE -> ISSUE, else -> DONE with err=1, rdata=0.
- ISSUE (1 cycle): m_wr=write, m_rd=!write. Write -> DONE (err=0, rdata=0). Read -> WAIT, timeout counter cleared.
- WAIT: if m_rd_valid -> capture m_rdata, err=0, -> DONE. Else counter++; when counter reaches TIMEOUT -> DONE, err=1, rdata=0.
- DONE (1 cycle): rsp_valid[idx]=1 with rsp_rdata/rsp_err; -> IDLE.
- req_ready is 0 in every state except IDLE; requests never queue inside the block.
- m_addr/m_wdata are registered, load at handshake only when address is in range, hold until the next accepted in-range request.
- m_wr/m_rd are never both high; high only in ISSUE.
- m_rd_valid outside WAIT is ignored.
- Reset values: state IDLE, last_grant NUM_REQ-1 (requester 0 wins first), req_ready 0 during reset, rsp_valid 0, rsp_rdata 0, rsp_err 0, m_addr 0, m_wdata 0, m_wr 0, m_rd 0.
- Reset asserted mid-transaction: immediate abort to IDLE, no rsp_valid for the aborted request; requester must reissue.

## Timing
- Handshake at edge T (IDLE). In-range write: m_wr high in cycle T+1, rsp_valid in T+2. Three cycles per write, back-to-back acceptance possible in T+3.
- In-range read against 1-cycle target: m_rd high T+1, m_rd_valid sampled high in T+2 (WAIT), rsp_valid with data in T+3.
- Out-of-range: rsp_valid err=1 in T+1; m_wr/m_rd never asserted.
- Read timeout: rsp_valid err=1 exactly TIMEOUT+2 cycles after the handshake cycle's successor (ISSUE + TIMEOUT WAIT cycles + DONE).
- Requester may drop req_valid while not granted; once accepted, req inputs are don't-care.

## Test plan
- Write 0xBEEF0004 <- 0x00000010 from req0, then read 0xBEEF0008 -> m_wr one cycle with m_addr=0xBEEF0004, rsp_valid[0] at T+2 err=0; read rsp_rdata=0x0000003A at T+3.
- req0 and req1 both hold valid reads of 0xBEEF0000 continuously after reset -> grants alternate 0,1,0,1; each rsp_valid only on the granted requester's bit.
- Read 0x12340000 from req1 -> rsp_valid[1] next cycle, rsp_err=1, rsp_rdata=0, m_rd/m_wr stay 0, m_addr unchanged.
- Target tied m_rd_valid=0, TIMEOUT=8, read 0xBEEF000C -> m_rd one pulse, rsp_valid with err=1, rdata=0 exactly 10 cycles after handshake.
- Drop rst to 0 in WAIT -> same cycle m_rd=0, rsp_valid=0, m_addr=0; after release req0 granted first and completes normally.
- Write 0xBEEF0000 <- 0xA5A5A5A5, read 0xBEEF000C -> rsp_rdata=0xA5A5A5A5, never m_wr and m_rd high together.
